// File: rtl/diff_unit.sv
// DIFF helper for the ALU: registers the index of the lowest differing bit of two operands.
// Defining DIFF_EQ_FLAG_EN adds a registered `equal` output.
module diff_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [31:0]      out
`ifdef DIFF_EQ_FLAG_EN
    ,
    output logic             equal
`endif
);

    // Lowest set bit of x, or WIDTH when x is zero. The scan runs from the top down
    // so the last assignment is the lowest set bit.
    function automatic logic [31:0] lsb_index(input logic [WIDTH-1:0] x);
        logic [31:0] idx;
        idx = 32'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (x[i]) begin
                idx = 32'(i);
            end
        end
        return idx;
    endfunction

    // Stage p0: combinational difference and priority encode
    logic [WIDTH-1:0] diff_p0;
    logic [31:0]      idx_p0;
    logic             eq_p0;

    always_comb begin
        diff_p0 = in1 ^ in2;
        idx_p0  = lsb_index(diff_p0);
        eq_p0   = (diff_p0 == '0);
    end

    // Stage p1: result register; data holds when no request arrives
    logic [31:0] idx_p1;
    logic        vld_p1;
    logic        eq_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            idx_p1 <= '0;
            eq_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                idx_p1 <= idx_p0;
                eq_p1  <= eq_p0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out       = idx_p1;

`ifdef DIFF_EQ_FLAG_EN
    assign equal = eq_p1;
`else
    logic unused_eq;
    assign unused_eq = eq_p1;
`endif

endmodule

// File: tb/tb_diff_unit.sv
// Directed-vector bench for diff_unit; checks the `equal` flag too when DIFF_EQ_FLAG_EN is defined.
module tb_diff_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic [31:0] out;
`ifdef DIFF_EQ_FLAG_EN
    logic        equal;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    diff_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out       (out)
`ifdef DIFF_EQ_FLAG_EN
        ,
        .equal     (equal)
`endif
    );

    // Drive one cycle of inputs, then settle just after the rising edge.
    task automatic step(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b);
        rst      = r;
        in_valid = v;
        in1      = a;
        in2      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 1'b1, 32'd5, 32'd0);
            vectors++;
            if (out_valid !== 1'b0 || out !== 32'd0) begin
                errors++;
                $display("FAIL reset[%0d]: got out_valid=%0b out=%0d, want out_valid=0 out=0", c, out_valid, out);
            end
`ifdef DIFF_EQ_FLAG_EN
            vectors++;
            if (equal !== 1'b0) begin
                errors++;
                $display("FAIL reset_equal[%0d]: got %0b, want 0", c, equal);
            end
`endif
        end
    endtask

    task automatic test_sweep();
        logic [31:0] exp_tab [10] = '{32, 0, 1, 0, 2, 0, 1, 0, 3, 0};
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 32'(i), 32'(2 * i));
            vectors++;
            if (out_valid !== 1'b1 || out !== exp_tab[i]) begin
                errors++;
                $display("FAIL sweep[%0d]: got out_valid=%0b out=%0d, want out_valid=1 out=%0d", i, out_valid, out, exp_tab[i]);
            end
`ifdef DIFF_EQ_FLAG_EN
            vectors++;
            if (equal !== (i == 0)) begin
                errors++;
                $display("FAIL sweep_equal[%0d]: got %0b, want %0b", i, equal, (i == 0));
            end
`endif
        end
    endtask

    task automatic test_edges();
        logic [31:0] a_tab   [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] b_tab   [3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] exp_tab [3] = '{31, 32, 0};
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, a_tab[k], b_tab[k]);
            vectors++;
            if (out_valid !== 1'b1 || out !== exp_tab[k]) begin
                errors++;
                $display("FAIL edge[%0d]: got out_valid=%0b out=%0d, want out_valid=1 out=%0d", k, out_valid, out, exp_tab[k]);
            end
`ifdef DIFF_EQ_FLAG_EN
            vectors++;
            if (equal !== (k == 1)) begin
                errors++;
                $display("FAIL edge_equal[%0d]: got %0b, want %0b", k, equal, (k == 1));
            end
`endif
        end
    endtask

    task automatic test_multibit();
        step(1'b0, 1'b1, 32'h00F0_0000, 32'h0010_0000);
        vectors++;
        if (out_valid !== 1'b1 || out !== 32'd21) begin
            errors++;
            $display("FAIL multibit: got out_valid=%0b out=%0d, want out_valid=1 out=21", out_valid, out);
        end
    endtask

    task automatic test_hold();
        step(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000);
        vectors++;
        if (out_valid !== 1'b1 || out !== 32'd6) begin
            errors++;
            $display("FAIL hold_load: got out_valid=%0b out=%0d, want out_valid=1 out=6", out_valid, out);
        end
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b0, 32'h0000_0001, 32'h0000_0000);
            vectors++;
            if (out_valid !== 1'b0 || out !== 32'd6) begin
                errors++;
                $display("FAIL hold[%0d]: got out_valid=%0b out=%0d, want out_valid=0 out=6", c, out_valid, out);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_tab   [6] = '{32'h0000_0010, 32'h0000_0300, 32'h1234_5678, 32'h0000_0008, 32'h4000_0000, 32'hAAAA_AAAA};
        logic [31:0] b_tab   [6] = '{32'h0000_0000, 32'h0000_0100, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'hAAAA_AAAB};
        logic        r_tab   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_tab [6] = '{4, 9, 32, 0, 30, 0};
        logic        vexp    [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            step(r_tab[k], 1'b1, a_tab[k], b_tab[k]);
            vectors++;
            if (out_valid !== vexp[k] || out !== exp_tab[k]) begin
                errors++;
                $display("FAIL b2b[%0d]: got out_valid=%0b out=%0d, want out_valid=%0b out=%0d", k, out_valid, out, vexp[k], exp_tab[k]);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in1      = '0;
        in2      = '0;
        @(negedge clk);
        test_reset();
        test_sweep();
        test_edges();
        test_multibit();
        test_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
